// File: rtl/seg7_bcd_counter_display.sv
// N-digit BCD up/down counter with a time-multiplexed 7-segment display.
// The count and scan prescalers run from CLK. The display outputs are registered
// one cycle behind the scan index and VALUE that they reflect.
module seg7_bcd_counter_display #(
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned CNT_DIV     = 50000000,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned BLANK_ZEROS = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REVERSE,
    input  logic                  HOLD,
    input  logic                  CLEAR,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic                  CARRY,
    output logic [DIGITS-1:0]     DSEL,
    output logic [7:0]            DOUT
);

    localparam int unsigned CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(CNT_DIV - 1);
    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_POL   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DSEL_POL  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [DIGITS-1:0] DSEL_ONE  = DIGITS'(1);

    logic [CW-1:0]     cpre_q, cpre_d;
    logic [SW-1:0]     spre_q, spre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     value_q, value_d;
    logic              carry_q, carry_d;
    logic [DIGITS-1:0] dsel_q, dsel_d;
    logic [7:0]        dout_q, dout_d;

    logic              cnt_tick_c;
    logic              scan_tick_c;
    logic              ripple_c;
    logic [3:0]        dig_c;
    logic [3:0]        cur_c;
    logic              nz_c;
    logic              blank_c;

    // Active-high {dp,g,f,e,d,c,b,a} pattern of one BCD digit.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign cnt_tick_c  = (cpre_q == CNT_LAST);
    assign scan_tick_c = (spre_q == SCAN_LAST);

    // Count prescaler and BCD count. Clear has priority and discards the tick. A wrap
    // pulses carry.
    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        ripple_c = 1'b0;
        dig_c    = 4'd0;
        cpre_d   = cnt_tick_c ? '0 : cpre_q + CW'(1);
        if (CLEAR) begin
            value_d = '0;
            cpre_d  = '0;
        end else if (cnt_tick_c && !HOLD) begin
            ripple_c = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                dig_c = value_q[4*i +: 4];
                if (ripple_c) begin
                    if (!REVERSE) begin
                        if (dig_c == 4'd9) begin
                            value_d[4*i +: 4] = 4'd0;
                        end else begin
                            value_d[4*i +: 4] = dig_c + 4'd1;
                            ripple_c = 1'b0;
                        end
                    end else begin
                        if (dig_c == 4'd0) begin
                            value_d[4*i +: 4] = 4'd9;
                        end else begin
                            value_d[4*i +: 4] = dig_c - 4'd1;
                            ripple_c = 1'b0;
                        end
                    end
                end
            end
            carry_d = ripple_c;
        end
    end

    // Scan prescaler and digit index. Neither CLEAR nor HOLD affects them.
    always_comb begin
        spre_d = scan_tick_c ? '0 : spre_q + SW'(1);
        idx_d  = idx_q;
        if (scan_tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Digit select and segments for the current index. A leading zero digit is blanked.
    always_comb begin
        cur_c  = 4'd0;
        nz_c   = 1'b0;
        dsel_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_c     = value_q[4*i +: 4];
                dsel_d[i] = 1'b1;
            end
            if ((IW'(i) >= idx_q) && (value_q[4*i +: 4] != 4'd0)) begin
                nz_c = 1'b1;
            end
        end
        blank_c = (BLANK_ZEROS != 0) && (idx_q != '0) && !nz_c;
        dsel_d  = dsel_d ^ DSEL_POL;
        dout_d  = (blank_c ? 8'h00 : seg_decode(cur_c)) ^ SEG_POL;
    end

    // State and output registers. Reset takes effect asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cpre_q  <= '0;
            spre_q  <= '0;
            idx_q   <= '0;
            value_q <= '0;
            carry_q <= 1'b0;
            dsel_q  <= DSEL_ONE ^ DSEL_POL;
            dout_q  <= 8'h3F ^ SEG_POL;
        end else begin
            cpre_q  <= cpre_d;
            spre_q  <= spre_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            carry_q <= carry_d;
            dsel_q  <= dsel_d;
            dout_q  <= dout_d;
        end
    end

    assign VALUE = value_q;
    assign CARRY = carry_q;
    assign DSEL  = dsel_q;
    assign DOUT  = dout_q;

endmodule
